// File: rtl/rv32i_operand_stage.sv
// Registered ALU operand selection for rv32i: immediate decode, multi-source
// bypass, and a single-entry valid/ready output register with flush.

module rv32i_operand_fwd #(
    parameter int XLEN = 32,
    parameter int NFWD = 2
) (
    input  logic [4:0]           rs,
    input  logic [XLEN-1:0]      rdata,
    input  logic [NFWD-1:0]      fwdValid,
    input  logic [NFWD*5-1:0]    fwdRd,
    input  logic [NFWD*XLEN-1:0] fwdData,
    output logic [XLEN-1:0]      val
);
    // Walk from the lowest-priority source up so that index 0 wins last.
    always_comb begin
        val = rdata;
        if (rs != 5'd0) begin
            for (int k = NFWD - 1; k >= 0; k--) begin
                if (fwdValid[k] && (fwdRd[5*k +: 5] == rs))
                    val = fwdData[XLEN*k +: XLEN];
            end
        end
    end
endmodule

module rv32i_operand_stage #(
    parameter int XLEN = 32,
    parameter int NFWD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [31:0]          ins,
    input  logic [XLEN-1:0]      pc,
    input  logic [XLEN-1:0]      rs1Data,
    input  logic [XLEN-1:0]      rs2Data,
    input  logic [3:0]           sel1,
    input  logic [3:0]           sel2,
    input  logic [NFWD-1:0]      fwdValid,
    input  logic [NFWD*5-1:0]    fwdRd,
    input  logic [NFWD*XLEN-1:0] fwdData,
    input  logic                 flush,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [XLEN-1:0]      out1,
    output logic [XLEN-1:0]      out2,
    output logic [XLEN-1:0]      outStore,
    output logic                 outIllegal,
    output logic [15:0]          stallCnt
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] st;
        logic            ill;
    } entry_t;

    state_t state_q, state_d;
    entry_t ent_q, ent_d;
    logic   cap;

    logic [1:0][4:0]      rsIdx;
    logic [1:0][XLEN-1:0] rdat;
    logic [1:0][XLEN-1:0] fval;

    assign rsIdx[0] = ins[19:15];
    assign rsIdx[1] = ins[24:20];
    assign rdat[0]  = rs1Data;
    assign rdat[1]  = rs2Data;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_fwd
            rv32i_operand_fwd #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd (
                .rs      (rsIdx[g]),
                .rdata   (rdat[g]),
                .fwdValid(fwdValid),
                .fwdRd   (fwdRd),
                .fwdData (fwdData),
                .val     (fval[g])
            );
        end
    endgenerate

    logic [XLEN-1:0] immI, immS, immB, immU, immJ, shamt;
    logic [5:0]      sh;

    always_comb begin
        immI  = XLEN'($signed(ins[31:20]));
        immS  = XLEN'($signed({ins[31:25], ins[11:7]}));
        immB  = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        immU  = XLEN'($signed({ins[31:12], 12'h000}));
        immJ  = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        // RV64 shifts take a 6-bit amount; RV32 keeps ins[25] out of it.
        sh    = (XLEN == 64) ? ins[25:20] : {1'b0, ins[24:20]};
        shamt = XLEN'(sh);
    end

    always_comb begin
        ent_d     = '0;
        ent_d.st  = fval[1];
        case (sel1)
            4'd0:    ent_d.op1 = fval[0];
            4'd1:    ent_d.op1 = pc;
            4'd2:    ent_d.op1 = '0;
            default: ent_d.ill = 1'b1;
        endcase
        case (sel2)
            4'd0:    ent_d.op2 = fval[1];
            4'd1:    ent_d.op2 = immI;
            4'd2:    ent_d.op2 = shamt;
            4'd3:    ent_d.op2 = immS;
            4'd4:    ent_d.op2 = immU;
            4'd5:    ent_d.op2 = immB;
            4'd6:    ent_d.op2 = immJ;
            4'd7:    ent_d.op2 = XLEN'(4);
            default: ent_d.ill = 1'b1;
        endcase
    end

    assign outValid = (state_q == FULL);
    assign inReady  = !outValid || outReady;
    assign cap      = inValid && inReady && !flush;

    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = EMPTY;
        else if (cap)
            state_d = FULL;
        else if (outReady)
            state_d = EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            ent_q    <= '0;
            stallCnt <= 16'd0;
        end else begin
            state_q <= state_d;
            if (cap)
                ent_q <= ent_d;
            if (outValid && !outReady && (stallCnt != 16'hFFFF))
                stallCnt <= stallCnt + 16'd1;
        end
    end

    assign out1       = ent_q.op1;
    assign out2       = ent_q.op2;
    assign outStore   = ent_q.st;
    assign outIllegal = ent_q.ill;
endmodule

// File: tb/tb_rv32i_operand_stage.sv
// Directed checks of rv32i_operand_stage: operand muxing, bypass priority,
// flow control, flush, stall counting and asynchronous reset.

module tb_rv32i_operand_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        inValid, inReady;
    logic [31:0] ins, pc, rs1Data, rs2Data;
    logic [3:0]  sel1, sel2;
    logic [1:0]  fwdValid;
    logic [9:0]  fwdRd;
    logic [63:0] fwdData;
    logic        flush, outValid, outReady, outIllegal;
    logic [31:0] out1, out2, outStore;
    logic [15:0] stallCnt;

    int checks = 0;
    int fails  = 0;

    rv32i_operand_stage #(.XLEN(32), .NFWD(2)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .ins(ins), .pc(pc), .rs1Data(rs1Data), .rs2Data(rs2Data),
        .sel1(sel1), .sel2(sel2), .fwdValid(fwdValid), .fwdRd(fwdRd),
        .fwdData(fwdData), .flush(flush), .outValid(outValid),
        .outReady(outReady), .out1(out1), .out2(out2), .outStore(outStore),
        .outIllegal(outIllegal), .stallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; inValid = 1'b0; ins = 32'h0; pc = 32'h0;
        rs1Data = 32'h0; rs2Data = 32'h0; sel1 = 4'd0; sel2 = 4'd0;
        fwdValid = 2'b00; fwdRd = 10'h0; fwdData = 64'h0;
        flush = 1'b0; outReady = 1'b1;
        #3;
        chk("rst_outValid", outValid, 0);
        chk("rst_inReady", inReady, 1);
        chk("rst_stallCnt", stallCnt, 0);
        chk("rst_out1", out1, 0);
        @(posedge clk);
        #3 rst = 1'b0;

        // addi x5,x1,-1 with sel2 = I-imm
        ins = 32'hFFF08293; rs1Data = 32'd10; rs2Data = 32'h55;
        sel1 = 4'd0; sel2 = 4'd1; inValid = 1'b1;
        step();
        chk("addi_valid", outValid, 1);
        chk("addi_out1", out1, 32'h0000000A);
        chk("addi_out2", out2, 32'hFFFFFFFF);
        chk("addi_ill", outIllegal, 0);
        chk("addi_store", outStore, 32'h55);

        // other sel2 decodes on the same word (rs2 field = 31)
        sel2 = 4'd3; step(); chk("simm", out2, 32'hFFFFFFE5);
        sel2 = 4'd4; step(); chk("uimm", out2, 32'hFFF08000);
        sel2 = 4'd2; step(); chk("shamt", out2, 32'h0000001F);
        sel2 = 4'd7; sel1 = 4'd2; step();
        chk("const4", out2, 32'h4);
        chk("zero_op1", out1, 32'h0);

        // forwarding priority: both sources hit rs1=1, index 0 wins
        sel1 = 4'd0; sel2 = 4'd1;
        fwdValid = 2'b11; fwdRd = {5'd1, 5'd1}; fwdData = {32'hBBBB, 32'hAAAA};
        step(); chk("fwd_prio", out1, 32'hAAAA);
        fwdRd = {5'd1, 5'd2};
        step(); chk("fwd_src1", out1, 32'hBBBB);
        fwdRd = {5'd1, 5'd31}; sel2 = 4'd0;
        step();
        chk("fwd_rs2_store", outStore, 32'hAAAA);
        chk("fwd_rs2_op2", out2, 32'hAAAA);
        // x0 is never forwarded
        ins = 32'h00000013; rs1Data = 32'h0; fwdRd = {5'd0, 5'd0};
        step(); chk("fwd_x0", out1, 32'h0);
        fwdValid = 2'b00;

        // branch / jump immediates
        ins = 32'hFE000EE3; sel1 = 4'd1; pc = 32'h100; sel2 = 4'd5;
        step();
        chk("b_out1", out1, 32'h100);
        chk("b_imm", out2, 32'hFFFFFFFC);
        ins = 32'hFF9FF06F; sel2 = 4'd6;
        step(); chk("j_imm", out2, 32'hFFFFFFF8);

        // illegal selects
        sel2 = 4'hA;
        step();
        chk("ill_out2", out2, 32'h0);
        chk("ill_flag", outIllegal, 1);
        sel1 = 4'd3; sel2 = 4'd1;
        step();
        chk("ill1_out1", out1, 32'h0);
        chk("ill1_flag", outIllegal, 1);

        // backpressure: capture, then stall three cycles with new input waiting
        ins = 32'hFFF08293; sel1 = 4'd0; sel2 = 4'd1; rs1Data = 32'd10;
        step();
        chk("bp_cap", out1, 32'hA);
        chk("bp_cnt0", stallCnt, 0);
        outReady = 1'b0; rs1Data = 32'd77;
        step(); step(); step();
        chk("bp_inReady", inReady, 0);
        chk("bp_hold_out1", out1, 32'hA);
        chk("bp_hold_valid", outValid, 1);
        chk("bp_cnt3", stallCnt, 3);
        outReady = 1'b1;
        step();
        chk("bp_next_valid", outValid, 1);
        chk("bp_next_out1", out1, 32'd77);
        chk("bp_cnt_keep", stallCnt, 3);

        // flush while EMPTY
        inValid = 1'b0; step();
        chk("drain", outValid, 0);
        inValid = 1'b1; flush = 1'b1; step();
        chk("flush_empty", outValid, 0);
        // flush while FULL under backpressure (that cycle is still a stall)
        flush = 1'b0; step();
        chk("refill", outValid, 1);
        outReady = 1'b0; flush = 1'b1; inValid = 1'b0;
        step();
        chk("flush_full", outValid, 0);
        chk("flush_cnt", stallCnt, 4);
        flush = 1'b0; step();
        chk("flush_cnt_keep", stallCnt, 4);

        // async reset mid-stall
        outReady = 1'b1; inValid = 1'b1; rs2Data = 32'h1234; sel2 = 4'hB;
        step();
        inValid = 1'b0; outReady = 1'b0;
        step();
        chk("pre_rst_cnt", stallCnt, 5);
        chk("pre_rst_ill", outIllegal, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", outValid, 0);
        chk("arst_out1", out1, 0);
        chk("arst_out2", out2, 0);
        chk("arst_store", outStore, 0);
        chk("arst_ill", outIllegal, 0);
        chk("arst_cnt", stallCnt, 0);
        chk("arst_inReady", inReady, 1);
        step();
        #3 rst = 1'b0;
        inValid = 1'b1; outReady = 1'b1; sel2 = 4'd1;
        step();
        chk("post_rst_cap", outValid, 1);
        chk("post_rst_out1", out1, 32'd77);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
